// File: rtl/dpram_fifo_ctrl.sv
`timescale 1ns/1ps
// FIFO controller over a dual-port RAM (A = write, B = read) with a 2-entry output skid buffer
// that hides the RAM's one-cycle read latency so the consumer side sustains one word per clock.
module dpram_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] ram_address_a,
    output logic [DATA_WIDTH-1:0] ram_data_a,
    output logic                  ram_wren_a,
    output logic [ADDR_WIDTH-1:0] ram_address_b,
    output logic [DATA_WIDTH-1:0] ram_data_b,
    output logic                  ram_wren_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);

    localparam int unsigned CntW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DepthCnt = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d, count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            skid_cnt_q, skid_cnt_d;
    logic [DATA_WIDTH-1:0] skid0_q, skid0_d, skid1_q, skid1_d;
    logic                  accept, pop, issue;
    logic [2:0]            occ;
    logic [1:0]            wr_idx;

    // in_ready is held low while reset is asserted.
    assign in_ready  = reset_n & (ram_cnt_q != DepthCnt);
    assign accept    = in_valid & in_ready;
    assign out_valid = (skid_cnt_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign occ       = {1'b0, skid_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (ram_cnt_q != '0) & (occ < 3'd2);

    assign out_data      = skid0_q;
    assign count         = count_q;
    assign ram_address_a = wr_ptr_q;
    assign ram_data_a    = in_data;
    assign ram_wren_a    = accept;
    assign ram_address_b = rd_ptr_q;
    assign ram_data_b    = '0;
    assign ram_wren_b    = 1'b0;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(accept);
        rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(issue);
        ram_cnt_d  = ram_cnt_q + CntW'(accept) - CntW'(issue);
        inflight_d = issue;

        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        if (pop) begin
            skid0_d = skid1_q;
        end
        // A captured word lands behind whatever survives this edge's pop.
        wr_idx = skid_cnt_q - {1'b0, pop};
        if (inflight_q) begin
            if (wr_idx == 2'd0) begin
                skid0_d = ram_q_b;
            end else begin
                skid1_d = ram_q_b;
            end
        end
        skid_cnt_d = skid_cnt_q + {1'b0, inflight_q} - {1'b0, pop};

        count_d = ram_cnt_d + CntW'(inflight_d) + CntW'(skid_cnt_d);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            skid_cnt_q <= 2'd0;
            skid0_q    <= '0;
            skid1_q    <= '0;
            count_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            skid_cnt_q <= skid_cnt_d;
            skid0_q    <= skid0_d;
            skid1_q    <= skid1_d;
            count_q    <= count_d;
        end
    end

endmodule
